// File: rtl/seq_radix4_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : seq_radix4_multiplier
//  Purpose  : Iterative radix-4 multiplier. It retires one 2-bit multiplier
//             digit per clock by adding a precomputed 0x/1x/2x/3x multiple of
//             the multiplicand into a 2*WIDTH accumulator. It supports signed
//             (two's-complement) and unsigned operands, uses a start/busy/done
//             handshake, and can optionally terminate early.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clock     in   1        rising-edge clock
//    Reset     in   1        asynchronous active-high reset, clears all state
//    iStart    in   1        operation request, sampled only while idle
//    iSigned   in   1        1 = operands are two's complement
//    iA        in   WIDTH    multiplicand
//    iB        in   WIDTH    multiplier
//    oBusy     out  1        high while an operation is in flight
//    oDone     out  1        one-cycle pulse when oProduct updates
//    oProduct  out  2*WIDTH  last completed product, held until the next one
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH       operand width in bits, even and >= 4
//    EARLY_EXIT  1 = finish once the remaining multiplier digits are all zero
// ============================================================================
module seq_radix4_multiplier #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic               iSigned,
  input  logic [WIDTH-1:0]   iA,
  input  logic [WIDTH-1:0]   iB,
  output logic               oBusy,
  output logic               oDone,
  output logic [2*WIDTH-1:0] oProduct
);

  localparam int PW     = 2 * WIDTH;          // product / accumulator width
  localparam int PPW    = WIDTH + 2;          // width of one partial product
  localparam int DIGITS = WIDTH / 2;          // radix-4 digits per operand
  localparam int CW     = $clog2(DIGITS + 1); // counter / position width

  localparam logic [CW-1:0]    C_DIGITS = CW'(DIGITS);
  localparam logic [CW-1:0]    C_ONE_CW = CW'(1);
  localparam logic [WIDTH-1:0] C_ONE_W  = WIDTH'(1);
  localparam logic [PW-1:0]    C_ONE_P  = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_FINISH  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  state_t            state_q;
  logic [WIDTH-1:0]  mA_q;    // multiplicand magnitude
  logic [WIDTH-1:0]  mB_q;    // remaining multiplier magnitude (shifts right)
  logic              neg_q;   // final product must be negated
  logic [PW-1:0]     acc_q;   // unsigned magnitude accumulator
  logic [CW-1:0]     pos_q;   // digit position of the current partial product
  logic [CW-1:0]     cnt_q;   // digits still to process

  // --------------------------------------------------------------------------
  // Next-state / datapath signals
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]  absA_d;
  logic [WIDTH-1:0]  absB_d;
  logic              neg_d;
  logic [1:0]        digit_d;
  logic [PPW-1:0]    mA1_d;
  logic [PPW-1:0]    mA2_d;
  logic [PPW-1:0]    mA3_d;
  logic [PPW-1:0]    pp_d;
  logic [PW-1:0]     ppx_d;
  logic [PW-1:0]     acc_d;
  logic [WIDTH-1:0]  mB_d;
  logic [CW-1:0]     pos_d;
  logic [CW-1:0]     cnt_d;
  logic              last_d;
  logic [PW-1:0]     prod_d;

  // Operand conditioning at start. The magnitude of -2^(WIDTH-1) is
  // 2^(WIDTH-1), which still fits unsigned in WIDTH bits, so the plain
  // two's-complement negation is exact here.
  always_comb begin
    absA_d = iA;
    absB_d = iB;
    if (iSigned && iA[WIDTH-1]) begin
      absA_d = (~iA) + C_ONE_W;
    end
    if (iSigned && iB[WIDTH-1]) begin
      absB_d = (~iB) + C_ONE_W;
    end
    neg_d = iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
  end

  // One radix-4 step: select the multiple for the low digit of mB, align it
  // to the current digit position and accumulate.
  always_comb begin
    digit_d = mB_q[1:0];
    mA1_d   = {2'b00, mA_q};
    mA2_d   = {1'b0, mA_q, 1'b0};
    mA3_d   = mA2_d + mA1_d;

    case (digit_d)
      2'd0:    pp_d = '0;
      2'd1:    pp_d = mA1_d;
      2'd2:    pp_d = mA2_d;
      default: pp_d = mA3_d;
    endcase

    ppx_d = {{(PW - PPW){1'b0}}, pp_d};
    acc_d = acc_q + (ppx_d << {pos_q, 1'b0});

    mB_d  = mB_q >> 2;
    pos_d = pos_q + C_ONE_CW;
    cnt_d = cnt_q - C_ONE_CW;

    // Early exit looks at the multiplier after this step's shift: once no
    // set bits remain, every later partial product would be zero.
    last_d = (cnt_d == '0) || (EARLY_EXIT && (mB_d == '0));

    // Zero magnitude with neg set negates to zero, so no special case.
    prod_d = neg_q ? ((~acc_q) + C_ONE_P) : acc_q;
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      mA_q     <= '0;
      mB_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      pos_q    <= '0;
      cnt_q    <= '0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oProduct <= '0;
    end else begin
      oDone <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // oDone is high during the first IDLE cycle, so a start presented
          // alongside it is accepted here with no dead cycle.
          if (iStart) begin
            mA_q    <= absA_d;
            mB_q    <= absB_d;
            neg_q   <= neg_d;
            acc_q   <= '0;
            pos_q   <= '0;
            cnt_q   <= C_DIGITS;
            oBusy   <= 1'b1;
            state_q <= S_COMPUTE;
          end
        end

        S_COMPUTE: begin
          // iStart is ignored while busy; operands stay as latched.
          acc_q <= acc_d;
          mB_q  <= mB_d;
          pos_q <= pos_d;
          cnt_q <= cnt_d;
          if (last_d) begin
            state_q <= S_FINISH;
          end
        end

        S_FINISH: begin
          oProduct <= prod_d;
          oDone    <= 1'b1;
          oBusy    <= 1'b0;
          state_q  <= S_IDLE;
        end

        default: begin
          oBusy   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_radix4_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_radix4_multiplier
//  Purpose  : Directed self-checking bench for seq_radix4_multiplier. One
//             instance runs in fixed-latency mode, a second one with early
//             exit enabled. Operands and reset are shared; each instance
//             has its own start strobe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_radix4_multiplier;

  logic        Clock;
  logic        Reset;
  logic        iStart0;
  logic        iStart1;
  logic        iSigned;
  logic [15:0] iA;
  logic [15:0] iB;

  logic        oBusy0,  oBusy1;
  logic        oDone0,  oDone1;
  logic [31:0] oProduct0, oProduct1;

  int total;
  int bad;

  seq_radix4_multiplier #(
    .WIDTH      (16),
    .EARLY_EXIT (1'b0)
  ) u_dut_fix (
    .Clock    (Clock),
    .Reset    (Reset),
    .iStart   (iStart0),
    .iSigned  (iSigned),
    .iA       (iA),
    .iB       (iB),
    .oBusy    (oBusy0),
    .oDone    (oDone0),
    .oProduct (oProduct0)
  );

  seq_radix4_multiplier #(
    .WIDTH      (16),
    .EARLY_EXIT (1'b1)
  ) u_dut_early (
    .Clock    (Clock),
    .Reset    (Reset),
    .iStart   (iStart1),
    .iSigned  (iSigned),
    .iA       (iA),
    .iB       (iB),
    .oBusy    (oBusy1),
    .oDone    (oDone1),
    .oProduct (oProduct1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation on the selected instance and follow it to oDone.
  // Called at posedge+1; returns at posedge+1 of the oDone edge, so a
  // following call starts in the oDone cycle (back-to-back).
  task automatic run_op(input string tag, input bit which, input bit sgn,
                        input logic [15:0] a, input logic [15:0] b,
                        input int exp_lat, input logic [31:0] exp_p);
    logic [31:0] prev;
    int          lat;
    int          busy_n;
    bit          held;
    bit          got;
    prev    = which ? oProduct1 : oProduct0;
    iA      = a;
    iB      = b;
    iSigned = sgn;
    if (which) iStart1 = 1'b1;
    else       iStart0 = 1'b1;
    @(posedge Clock); #1;
    iStart0 = 1'b0;
    iStart1 = 1'b0;
    lat    = 0;
    busy_n = 0;
    held   = 1'b1;
    got    = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (which ? oDone1 : oDone0) begin
        got = 1'b1;
      end else begin
        if (which ? oBusy1 : oBusy0) busy_n++;
        if ((which ? oProduct1 : oProduct0) !== prev) held = 1'b0;
        @(posedge Clock); #1;
        lat++;
      end
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_latency"},   64'(lat), 64'(exp_lat));
    chk({tag, "_product"},   64'(which ? oProduct1 : oProduct0), 64'(exp_p));
    chk({tag, "_busy_cyc"},  64'(busy_n), 64'(exp_lat));
    chk({tag, "_held"},      64'(held), 64'd1);
  endtask

  initial begin
    int done_n;
    total   = 0;
    bad     = 0;
    Reset   = 1'b1;
    iStart0 = 1'b0;
    iStart1 = 1'b0;
    iSigned = 1'b0;
    iA      = '0;
    iB      = '0;

    // Reset state
    #12;
    chk("rst_busy0", 64'(oBusy0), 64'd0);
    chk("rst_done0", 64'(oDone0), 64'd0);
    chk("rst_prod0", 64'(oProduct0), 64'd0);
    chk("rst_prod1", 64'(oProduct1), 64'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(posedge Clock); #1;

    // Unsigned full-scale
    run_op("u_ffff_ffff", 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 9, 32'hFFFE0001);

    // Signed cases
    run_op("s_m3_x5",     1'b0, 1'b1, 16'hFFFD, 16'h0005, 9, 32'hFFFFFFF1);
    run_op("s_min_min",   1'b0, 1'b1, 16'h8000, 16'h8000, 9, 32'h40000000);
    run_op("s_min_x1",    1'b0, 1'b1, 16'h8000, 16'h0001, 9, 32'hFFFF8000);
    run_op("s_zero_neg",  1'b0, 1'b1, 16'h0000, 16'hFFFF, 9, 32'h00000000);

    // Busy protection: extra start pulses on edges 3 and 5 of the operation
    @(posedge Clock); #1;
    iA = 16'h1234; iB = 16'h0010; iSigned = 1'b0; iStart0 = 1'b1;
    @(posedge Clock); #1;
    iStart0 = 1'b0;
    done_n  = 0;
    for (int k = 0; k < 20; k++) begin
      if (oDone0) begin
        done_n++;
        chk("busy_prot_done_edge", 64'(k), 64'd9);
        chk("busy_prot_product", 64'(oProduct0), 64'h00012340);
      end
      if (k == 2 || k == 4) begin
        iA = 16'hFFFF; iB = 16'hFFFF; iSigned = 1'b1; iStart0 = 1'b1;
      end else begin
        iStart0 = 1'b0;
      end
      @(posedge Clock); #1;
    end
    iStart0 = 1'b0;
    chk("busy_prot_done_count", 64'(done_n), 64'd1);

    // Back-to-back: second start issued in the oDone cycle of the first
    run_op("b2b_first",  1'b0, 1'b0, 16'h0003, 16'h0005, 9, 32'h0000000F);
    run_op("b2b_second", 1'b0, 1'b0, 16'h0007, 16'h0009, 9, 32'h0000003F);

    // Early-exit instance
    run_op("ee_7x3",     1'b1, 1'b0, 16'h0007, 16'h0003, 2, 32'h00000015);
    run_op("ee_7x0",     1'b1, 1'b0, 16'h0007, 16'h0000, 2, 32'h00000000);
    run_op("ee_7xc000",  1'b1, 1'b0, 16'h0007, 16'hC000, 9, 32'h00054000);
    run_op("ee_7x40",    1'b1, 1'b0, 16'h0007, 16'h0040, 5, 32'h000001C0);

    // Asynchronous reset in the middle of cycle 4 of an operation
    @(posedge Clock); #1;
    iA = 16'hFFFF; iB = 16'hFFFF; iSigned = 1'b0; iStart0 = 1'b1;
    @(posedge Clock); #1;
    iStart0 = 1'b0;
    repeat (3) begin
      @(posedge Clock); #1;
    end
    chk("mid_busy_before_rst", 64'(oBusy0), 64'd1);
    #3;
    Reset = 1'b1;
    #1;
    chk("arst_busy0", 64'(oBusy0), 64'd0);
    chk("arst_done0", 64'(oDone0), 64'd0);
    chk("arst_prod0", 64'(oProduct0), 64'd0);
    chk("arst_prod1", 64'(oProduct1), 64'd0);
    @(posedge Clock); #1;
    Reset  = 1'b0;
    done_n = 0;
    for (int k = 0; k < 15; k++) begin
      if (oDone0) done_n++;
      @(posedge Clock); #1;
    end
    chk("arst_no_done", 64'(done_n), 64'd0);
    chk("arst_idle_busy", 64'(oBusy0), 64'd0);

    run_op("after_rst", 1'b0, 1'b0, 16'h0002, 16'h0003, 9, 32'h00000006);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
